// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: bundles the ID-side inputs, forwarding producers and ALU/EX outputs of the operand stage.
interface id_ex_operand_stage_if #(parameter int XLEN = 32);
    logic            i_stall;
    logic            i_flush;
    logic            i_id_valid;
    logic [XLEN-1:0] i_id_pc;
    logic [XLEN-1:0] i_id_rs1_data;
    logic [XLEN-1:0] i_id_rs2_data;
    logic [XLEN-1:0] i_id_imm;
    logic [4:0]      i_id_rs1_addr;
    logic [4:0]      i_id_rs2_addr;
    logic [4:0]      i_id_rd_addr;
    logic [3:0]      i_id_alufn;
    logic            i_id_asel;
    logic            i_id_bsel;
    logic            i_id_regwrite;
    logic            i_id_memread;
    logic            i_id_memwrite;
    logic            i_mem_regwrite;
    logic [4:0]      i_mem_rd;
    logic [XLEN-1:0] i_mem_result;
    logic            i_wb_regwrite;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_result;
    logic [XLEN-1:0] o_alu_a;
    logic [XLEN-1:0] o_alu_b;
    logic [4:0]      o_alu_shamt;
    logic [3:0]      o_alu_alufn;
    logic            o_ex_valid;
    logic            o_ex_regwrite;
    logic            o_ex_memread;
    logic            o_ex_memwrite;
    logic [4:0]      o_ex_rd;
    logic [XLEN-1:0] o_ex_pc;
    logic [XLEN-1:0] o_ex_store_data;
    logic            o_load_use_hazard;

    modport master (
        output i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_alufn, i_id_asel, i_id_bsel,
               i_id_regwrite, i_id_memread, i_id_memwrite, i_mem_regwrite, i_mem_rd, i_mem_result,
               i_wb_regwrite, i_wb_rd, i_wb_result,
        input  o_alu_a, o_alu_b, o_alu_shamt, o_alu_alufn, o_ex_valid, o_ex_regwrite, o_ex_memread,
               o_ex_memwrite, o_ex_rd, o_ex_pc, o_ex_store_data, o_load_use_hazard
    );

    modport slave (
        input  i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_alufn, i_id_asel, i_id_bsel,
               i_id_regwrite, i_id_memread, i_id_memwrite, i_mem_regwrite, i_mem_rd, i_mem_result,
               i_wb_regwrite, i_wb_rd, i_wb_result,
        output o_alu_a, o_alu_b, o_alu_shamt, o_alu_alufn, o_ex_valid, o_ex_regwrite, o_ex_memread,
               o_ex_memwrite, o_ex_rd, o_ex_pc, o_ex_store_data, o_load_use_hazard
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with EX/MEM and MEM/WB operand forwarding and load-use detection.
module id_ex_operand_stage #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    id_ex_operand_stage_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'h0;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd;
    logic [3:0]      r_alufn;
    logic            r_asel;
    logic            r_bsel;
    logic            r_regwrite;
    logic            r_memread;
    logic            r_memwrite;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_alu_b;

    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_res,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_res
    );
        return (src != 5'd0 && mem_we && mem_rd == src) ? mem_res :
               (src != 5'd0 && wb_we && wb_rd == src)   ? wb_res  : rf;
    endfunction

    always_comb begin
        w_fwd_rs1 = fwd(r_rs1_addr, r_rs1_data, bus.i_mem_regwrite, bus.i_mem_rd, bus.i_mem_result,
                        bus.i_wb_regwrite, bus.i_wb_rd, bus.i_wb_result);
        w_fwd_rs2 = fwd(r_rs2_addr, r_rs2_data, bus.i_mem_regwrite, bus.i_mem_rd, bus.i_mem_result,
                        bus.i_wb_regwrite, bus.i_wb_rd, bus.i_wb_result);
        w_alu_b   = r_bsel ? r_imm : w_fwd_rs2;
    end

    // Flush and reset produce the same bubble since ALU_ADD encodes as zero.
    always_ff @(posedge clk) begin
        if (rst || bus.i_flush) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd       <= '0;
            r_alufn    <= ALU_ADD;
            r_asel     <= 1'b0;
            r_bsel     <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (bus.i_stall) begin
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end else begin
            r_valid    <= bus.i_id_valid;
            r_pc       <= bus.i_id_pc;
            r_rs1_data <= bus.i_id_rs1_data;
            r_rs2_data <= bus.i_id_rs2_data;
            r_imm      <= bus.i_id_imm;
            r_rs1_addr <= bus.i_id_rs1_addr;
            r_rs2_addr <= bus.i_id_rs2_addr;
            r_rd       <= bus.i_id_rd_addr;
            r_alufn    <= bus.i_id_alufn;
            r_asel     <= bus.i_id_asel;
            r_bsel     <= bus.i_id_bsel;
            r_regwrite <= bus.i_id_regwrite;
            r_memread  <= bus.i_id_memread;
            r_memwrite <= bus.i_id_memwrite;
        end
    end

    always_comb begin
        bus.o_alu_a           = r_asel ? r_pc : w_fwd_rs1;
        bus.o_alu_b           = w_alu_b;
        bus.o_alu_shamt       = w_alu_b[4:0];
        bus.o_alu_alufn       = r_alufn;
        bus.o_ex_valid        = r_valid;
        bus.o_ex_regwrite     = r_regwrite;
        bus.o_ex_memread      = r_memread;
        bus.o_ex_memwrite     = r_memwrite;
        bus.o_ex_rd           = r_rd;
        bus.o_ex_pc           = r_pc;
        bus.o_ex_store_data   = w_fwd_rs2;
        bus.o_load_use_hazard = r_valid & r_memread & (r_rd != 5'd0) & bus.i_id_valid &
                                ((r_rd == bus.i_id_rs1_addr) | (r_rd == bus.i_id_rs2_addr));
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_id_ex_operand_stage;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SLL = 4'h1;

    typedef enum int {S_A, S_B, S_SHAMT, S_FN, S_VALID, S_RW, S_MR, S_MW, S_RD, S_PC, S_ST, S_HAZ} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    event smp;

    id_ex_operand_stage_if #(.XLEN(32)) bus ();

    id_ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] get(input sig_e s);
        case (s)
            S_A:     return bus.o_alu_a;
            S_B:     return bus.o_alu_b;
            S_SHAMT: return {27'd0, bus.o_alu_shamt};
            S_FN:    return {28'd0, bus.o_alu_alufn};
            S_VALID: return {31'd0, bus.o_ex_valid};
            S_RW:    return {31'd0, bus.o_ex_regwrite};
            S_MR:    return {31'd0, bus.o_ex_memread};
            S_MW:    return {31'd0, bus.o_ex_memwrite};
            S_RD:    return {27'd0, bus.o_ex_rd};
            S_PC:    return bus.o_ex_pc;
            S_ST:    return bus.o_ex_store_data;
            default: return {31'd0, bus.o_load_use_hazard};
        endcase
    endfunction

    initial forever begin
        @(smp);
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = get(e.sig);
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_sig(input string name, input sig_e s, input logic [31:0] v);
        q.push_back('{name, s, v});
    endtask

    task automatic sample();
        #1;
        -> smp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_stall = 0; bus.i_flush = 0; bus.i_id_valid = 0;
        bus.i_id_pc = 0; bus.i_id_rs1_data = 0; bus.i_id_rs2_data = 0; bus.i_id_imm = 0;
        bus.i_id_rs1_addr = 0; bus.i_id_rs2_addr = 0; bus.i_id_rd_addr = 0; bus.i_id_alufn = ALU_ADD;
        bus.i_id_asel = 0; bus.i_id_bsel = 0; bus.i_id_regwrite = 0; bus.i_id_memread = 0;
        bus.i_id_memwrite = 0; bus.i_mem_regwrite = 0; bus.i_mem_rd = 0; bus.i_mem_result = 0;
        bus.i_wb_regwrite = 0; bus.i_wb_rd = 0; bus.i_wb_result = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        bus.i_id_valid = 1'($urandom); bus.i_id_pc = $urandom; bus.i_id_rs1_data = $urandom;
        bus.i_id_rs2_data = $urandom; bus.i_id_imm = $urandom; bus.i_id_rs1_addr = 5'($urandom);
        bus.i_id_rs2_addr = 5'($urandom); bus.i_id_rd_addr = 5'($urandom); bus.i_id_alufn = 4'($urandom);
        bus.i_id_asel = 1'($urandom); bus.i_id_bsel = 1'($urandom); bus.i_id_regwrite = 1'($urandom);
        bus.i_id_memread = 1'($urandom); bus.i_id_memwrite = 1'($urandom);
        bus.i_mem_regwrite = 1; bus.i_mem_rd = 5'($urandom); bus.i_mem_result = $urandom;
        bus.i_wb_regwrite = 1; bus.i_wb_rd = 5'($urandom); bus.i_wb_result = $urandom;
        repeat (2) tick();
        expect_sig("rst_a", S_A, 0);       expect_sig("rst_b", S_B, 0);
        expect_sig("rst_shamt", S_SHAMT, 0); expect_sig("rst_fn", S_FN, {28'd0, ALU_ADD});
        expect_sig("rst_valid", S_VALID, 0); expect_sig("rst_rw", S_RW, 0);
        expect_sig("rst_mr", S_MR, 0);     expect_sig("rst_mw", S_MW, 0);
        expect_sig("rst_rd", S_RD, 0);     expect_sig("rst_pc", S_PC, 0);
        expect_sig("rst_st", S_ST, 0);     expect_sig("rst_haz", S_HAZ, 0);
        sample();
        rst = 0;
        clear_inputs();

        bus.i_id_valid = 1; bus.i_id_rs1_addr = 5; bus.i_id_rs1_data = 32'h99; bus.i_id_rs2_addr = 6;
        bus.i_id_rs2_data = 32'h66; bus.i_id_rd_addr = 3; bus.i_id_regwrite = 1; bus.i_id_pc = 32'h40;
        tick();
        clear_inputs();
        bus.i_mem_regwrite = 1; bus.i_mem_rd = 5; bus.i_mem_result = 32'h11;
        bus.i_wb_regwrite = 1; bus.i_wb_rd = 5; bus.i_wb_result = 32'h22;
        expect_sig("dbl_mem_a", S_A, 32'h11); expect_sig("dbl_b", S_B, 32'h66);
        expect_sig("dbl_valid", S_VALID, 1); expect_sig("dbl_rd", S_RD, 3);
        expect_sig("dbl_pc", S_PC, 32'h40); expect_sig("dbl_st", S_ST, 32'h66);
        expect_sig("dbl_rw", S_RW, 1);
        sample();
        bus.i_mem_regwrite = 0;
        expect_sig("dbl_wb_a", S_A, 32'h22);
        sample();
        bus.i_mem_regwrite = 1; bus.i_mem_rd = 6; bus.i_mem_result = 32'h77;
        expect_sig("fwd_rs2_b", S_B, 32'h77); expect_sig("fwd_rs2_st", S_ST, 32'h77);
        expect_sig("fwd_rs2_a_wb", S_A, 32'h22);
        sample();
        clear_inputs();

        bus.i_id_valid = 1; bus.i_id_rs1_addr = 0; bus.i_id_rs1_data = 32'h5; bus.i_id_rs2_addr = 0;
        tick();
        clear_inputs();
        bus.i_mem_regwrite = 1; bus.i_mem_rd = 0; bus.i_mem_result = 32'hDEAD;
        bus.i_wb_regwrite = 1; bus.i_wb_rd = 0; bus.i_wb_result = 32'hBEEF;
        expect_sig("x0_b", S_B, 0); expect_sig("x0_st", S_ST, 0); expect_sig("x0_a", S_A, 32'h5);
        sample();
        clear_inputs();

        bus.i_id_valid = 1; bus.i_id_bsel = 1; bus.i_id_imm = 32'h23; bus.i_id_alufn = ALU_SLL;
        bus.i_id_rs2_addr = 4; bus.i_id_rs2_data = 32'h1234; bus.i_id_rs1_addr = 1; bus.i_id_rs1_data = 32'hF0;
        tick();
        expect_sig("imm_b", S_B, 32'h23); expect_sig("imm_shamt", S_SHAMT, 3);
        expect_sig("imm_fn", S_FN, {28'd0, ALU_SLL}); expect_sig("imm_st", S_ST, 32'h1234);
        expect_sig("imm_a", S_A, 32'hF0);
        sample();
        clear_inputs();
        bus.i_id_valid = 1; bus.i_id_asel = 1; bus.i_id_pc = 32'h100; bus.i_id_bsel = 1;
        bus.i_id_imm = 32'h1000; bus.i_id_rs1_addr = 1; bus.i_id_rs1_data = 32'hAA;
        tick();
        expect_sig("auipc_a", S_A, 32'h100); expect_sig("auipc_b", S_B, 32'h1000);
        expect_sig("auipc_shamt", S_SHAMT, 0); expect_sig("auipc_pc", S_PC, 32'h100);
        sample();
        clear_inputs();

        bus.i_id_valid = 1; bus.i_id_memread = 1; bus.i_id_regwrite = 1; bus.i_id_rd_addr = 7;
        bus.i_id_rs1_addr = 2; bus.i_id_bsel = 1; bus.i_id_imm = 4;
        tick();
        clear_inputs();
        bus.i_id_valid = 1; bus.i_id_rs1_addr = 7; bus.i_id_rs2_addr = 3; bus.i_id_rd_addr = 8;
        bus.i_id_regwrite = 1;
        expect_sig("lu_haz_rs1", S_HAZ, 1); expect_sig("lu_mr", S_MR, 1); expect_sig("lu_rd", S_RD, 7);
        sample();
        bus.i_id_rs1_addr = 8;
        expect_sig("lu_nohaz", S_HAZ, 0);
        sample();
        bus.i_id_rs2_addr = 7;
        expect_sig("lu_haz_rs2", S_HAZ, 1);
        sample();
        bus.i_id_valid = 0;
        expect_sig("lu_id_invalid", S_HAZ, 0);
        sample();
        bus.i_id_valid = 1; bus.i_id_rs1_addr = 7; bus.i_flush = 1;
        tick();
        bus.i_flush = 0;
        expect_sig("flush_valid", S_VALID, 0); expect_sig("flush_rw", S_RW, 0);
        expect_sig("flush_mr", S_MR, 0); expect_sig("flush_rd", S_RD, 0);
        expect_sig("flush_fn", S_FN, {28'd0, ALU_ADD}); expect_sig("flush_haz", S_HAZ, 0);
        sample();
        clear_inputs();
        bus.i_id_valid = 1; bus.i_id_memread = 1; bus.i_id_rd_addr = 0;
        tick();
        bus.i_id_memread = 0; bus.i_id_rs1_addr = 0;
        expect_sig("lu_x0", S_HAZ, 0);
        sample();
        clear_inputs();

        bus.i_id_valid = 1; bus.i_id_rs1_addr = 9; bus.i_id_rs1_data = 32'h10; bus.i_id_rd_addr = 4;
        bus.i_id_regwrite = 1;
        tick();
        bus.i_stall = 1; bus.i_id_rs1_data = 32'hBAD; bus.i_id_rd_addr = 12; bus.i_id_pc = 32'h700;
        bus.i_wb_regwrite = 1; bus.i_wb_rd = 9; bus.i_wb_result = 32'h55;
        expect_sig("stall_comb_a", S_A, 32'h55);
        sample();
        tick();
        bus.i_wb_regwrite = 0; bus.i_wb_result = 32'h0;
        expect_sig("stall_held_a", S_A, 32'h55); expect_sig("stall_rd", S_RD, 4);
        sample();
        repeat (2) tick();
        bus.i_stall = 0;
        expect_sig("stall_rel_a", S_A, 32'h55); expect_sig("stall_rel_valid", S_VALID, 1);
        expect_sig("stall_rel_rd", S_RD, 4); expect_sig("stall_rel_pc", S_PC, 0);
        sample();
        bus.i_stall = 1; bus.i_flush = 1;
        tick();
        bus.i_flush = 0;
        expect_sig("sf_valid", S_VALID, 0); expect_sig("sf_rd", S_RD, 0); expect_sig("sf_a", S_A, 0);
        sample();
        clear_inputs();

        bus.i_id_valid = 1; bus.i_id_pc = 32'h200; bus.i_id_rd_addr = 5; bus.i_id_regwrite = 1;
        tick();
        bus.i_stall = 1; rst = 1;
        tick();
        rst = 0; bus.i_stall = 0;
        expect_sig("rst_stall_valid", S_VALID, 0); expect_sig("rst_stall_pc", S_PC, 0);
        expect_sig("rst_stall_rd", S_RD, 0);
        sample();

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the processor's main ALU. It captures decoded instruction fields each cycle and resolves EX/MEM and MEM/WB forwarding, then presents the ALU with `a`, `b`, `shamt` and `alufn`. It also flags load-use hazards to the hazard/fetch control and refreshes held operands during stalls.

## Interface
- `XLEN`, default 32: datapath width.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: reset, synchronous, active-high.
- `stall  in  1`: hold the EX register contents.
- `flush  in  1`: replace the EX contents with a bubble on the next edge.
- `id_valid  in  1`: the ID slot holds a real instruction.
- `id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN`: PC, register-file reads and sign-extended immediate.
- `id_rs1_addr, id_rs2_addr, id_rd_addr  in  5`: register indices.
- `id_alufn  in  4`: ALU function code, using the shared defines.
- `id_asel  in  1`: 1 selects PC as operand a (AUIPC/JAL); 0 selects rs1.
- `id_bsel  in  1`: 1 selects imm as operand b; 0 selects rs2.
- `id_regwrite, id_memread, id_memwrite  in  1`: control bits.
- `mem_regwrite  in  1`, `mem_rd  in  5`, `mem_result  in  XLEN`: EX/MEM producer.
- `wb_regwrite  in  1`, `wb_rd  in  5`, `wb_result  in  XLEN`: MEM/WB producer.
- `alu_a, alu_b  out  XLEN`: ALU operands.
- `alu_shamt  out  5`: ALU shift amount.
- `alu_alufn  out  4`: ALU function code.
- `ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1`: registered control.
- `ex_rd  out  5`: registered destination register.
- `ex_pc  out  XLEN`: registered PC.
- `ex_store_data  out  XLEN`: forwarded rs2 value, used for SW.
- `load_use_hazard  out  1`: request to the upstream stages to stall IF/ID and flush this stage.

## Operation
- Register update priority each edge: `rst` > `flush` > `stall` > load.
  - `rst`: every registered field is set to 0.
  - `flush`: valid and all control bits go to 0, `alufn` goes to `ALU_ADD`, and data and address fields go to 0.
  - `stall`: all fields hold, except the stored rs1 and rs2 data (see operand refresh below).
  - Load (no `rst`, `flush` or `stall`): capture all `id_*` inputs.
- Forwarding (combinational, for each of rs1 and rs2, using the registered address `src`):
  - If `src != 0`, `mem_regwrite`, `mem_rd == src`: use `mem_result`.
  - Else if `src != 0`, `wb_regwrite`, `wb_rd == src`: use `wb_result`.
  - Otherwise use the registered register-file value.
  - MEM wins over WB. Register x0 never forwards.
- Operand muxes:
  - `alu_a = asel_q ? pc_q : fwd_rs1`.
  - `alu_b = bsel_q ? imm_q : fwd_rs2`.
  - `alu_shamt = alu_b[4:0]`.
  - `ex_store_data = fwd_rs2`, regardless of `bsel`.
- Operand refresh: while `stall` is high and `flush` is low, the stored rs1 and rs2 data are overwritten with `fwd_rs1` and `fwd_rs2`. A producer that retires out of WB during a multi-cycle stall is therefore not lost.
- Load-use hazard: `load_use_hazard = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr))`. The block only reports the hazard; it never self-stalls.
- `ex_valid = 0` marks a bubble. Downstream stages gate side effects on `ex_valid`; the ALU still computes with the zeroed operands.

## Timing
- Latency: 1 cycle from ID inputs to `ex_*` and the ALU outputs.
- The forwarding path from `mem_result`/`wb_result` to `alu_a`/`alu_b` is purely combinational, with 0 cycles of latency.
- Reset values: all `ex_*` = 0, `alu_alufn = ALU_ADD`, `alu_a = alu_b = 0`, `alu_shamt = 0`.
- `load_use_hazard` is 0 after reset because `ex_valid = 0`.
- `flush` and `stall` in the same cycle: flush wins and a bubble is inserted.
- `rst` asserted mid-stall: the stage clears on that edge and `stall` is ignored.
- The hazard protocol is one bubble per load-use pair. Upstream stalls IF/ID for one cycle and asserts `flush` here. On the following cycle the load is in MEM, and the dependent instruction forwards from WB or MEM as applicable.

## Test plan
- Reset: hold `rst` for 2 cycles with random `id_*` values -> all outputs 0, `alu_alufn = ALU_ADD`, `load_use_hazard = 0`.
- Double forwarding: EX `rs1 = x5`, with `mem_rd = 5` carrying `0x11` and `wb_rd = 5` carrying `0x22`, both with regwrite -> `alu_a = 0x11`. Then drop `mem_regwrite` -> `alu_a = 0x22`.
- x0 guard: `rs2 = x0`, `mem_rd = 0`, `mem_result = 0xDEAD`, `bsel = 0` -> `alu_b` equals the registered rs2 data (0).
- Immediate shift: `bsel = 1`, `imm = 0x0000_0023`, `alufn = ALU_SLL` -> `alu_b = 0x23`, `alu_shamt = 3`. AUIPC case: `asel = 1`, `pc = 0x100` -> `alu_a = 0x100`.
- Load-use: EX holds a load with `rd = 7` and ID has `rs1 = 7` -> `load_use_hazard = 1`. Assert `flush` -> next cycle `ex_valid = 0` and `ex_regwrite = 0`.
- Stall refresh: stall 3 cycles with `wb_rd = 9` carrying `0x55` only in cycle 1; EX uses `rs1 = 9` -> after the stall releases, `alu_a = 0x55`. A simultaneous `stall` and `flush` -> bubble.
